cic_comp_fir: RTL and testbench
===============================

# cic_comp_fir

Serial symmetric FIR that pre-compensates the passband droop of the 3-stage CIC interpolator. Sits directly upstream of `cic_int_n3`. It takes samples at the low (pre-interpolation) rate on an `nd` strobe and computes one 13-tap output with one multiplier over 7 clocks. It then presents the result with a one-cycle `rdy` strobe that drives the CIC's `nd`.

## Interface
- `INPUT_WIDTH`, 15: signed input sample width.
- `OUTPUT_WIDTH`, 15: signed output width; matches the CIC `INPUT_WIDTH`.
- `COEF_WIDTH`, 16: signed coefficient width.
- `COEF_FRAC`, 14: coefficient fractional bits (Q1.14).
- `NTAPS`, 13: odd tap count; coefficients are symmetric.

Ports:
- `clk` in 1: single clock, 48 MHz in the system.
- `rst_n` in 1: asynchronous, active-low reset.
- `nd` in 1: new-data strobe, one cycle wide.
- `din` in INPUT_WIDTH: signed sample, valid when `nd`=1.
- `rdy` out 1: one-cycle strobe marking a new `dout`.
- `dout` out OUTPUT_WIDTH: signed filtered sample, held until the next `rdy`.
- `ovf` out 1: sticky overrun flag.

## Operation
- Coefficients h0..h6 are fixed constants: 12, -40, 100, -220, 240, -1400, 19000. h12-k = hk. The sum is 16384, so DC gain = 1.
- Delay line: NTAPS registers x0..x12, where x0 is the newest sample.
  - On an accepted `nd`, x0 <= `din` and xk <= xk-1.
- State machine, IDLE -> MAC -> OUT -> IDLE:
  - IDLE: `nd` is accepted. The delay line shifts, `acc` clears, tap index k = 0, and the next state is MAC.
  - MAC: lasts (NTAPS+1)/2 = 7 cycles.
    - For k < 6: acc += (xk + x12-k) * hk.
    - For k = 6: acc += x6 * h6. The centre tap is not doubled.
    - k increments each cycle; after k = 6 the state goes to OUT.
  - OUT: dout <= sat(round(acc)), `rdy` pulses, and the state returns to IDLE.
    - An `nd` in this same cycle is accepted as in IDLE, going directly to MAC.
- Width rules:
  - Pre-add is INPUT_WIDTH+1 bits.
  - Product is INPUT_WIDTH+1+COEF_WIDTH = 32 bits.
  - `acc` is 35 bits signed, so it cannot overflow.
- Rounding: round half up, computed as (acc + 2^(COEF_FRAC-1)) >>> COEF_FRAC, using an arithmetic shift.
- Saturation: see Configuration.
- Overrun: an `nd` arriving in MAC is dropped.
  - The delay line and computation are unaffected.
  - `ovf` is set to 1 and stays set until reset.

## Timing
- Reset values:
  - `rdy` = 0, `dout` = 0, `ovf` = 0.
  - Delay line = 0, `acc` = 0, state = IDLE.
- Reset is asynchronous. Asserting it mid-MAC aborts the computation immediately; no `rdy` is produced for that sample.
- Latency: `nd` sampled at edge E0 gives `rdy` = 1 and a new `dout` after edge E8, for one cycle.
- Minimum `nd` spacing is 8 clocks, which matches the CIC interpolation rate of 8.
  - With nd every 8 clocks, OUT and the next IDLE-accept coincide; both are required to work in the same cycle.
- `dout` changes only on the cycle `rdy` rises.
- `rdy` is never high on two consecutive cycles.

## Configuration
- Macro `CIC_COMP_SAT_EN`.
  - Defined: the rounded result is clamped to [-2^(OUTPUT_WIDTH-1), 2^(OUTPUT_WIDTH-1)-1].
  - Undefined: the rounded result is truncated to its low OUTPUT_WIDTH bits, i.e. two's-complement wrap.

## Test plan
All scenarios use `nd` every 8 clocks unless stated otherwise.
- Impulse: `din` = 1000 for one `nd`, then zeros.
  - Required 13 outputs: 1, -2, 6, -13, 15, -85, 1160, -85, 15, -13, 6, -2, 1, followed by 0.
- DC: constant `din` = 1000.
  - From the 13th `rdy` onward, `dout` = 1000. `ovf` stays 0.
- Saturation: a single `din` = 16383 impulse.
  - Centre output is 16383 with `CIC_COMP_SAT_EN` defined, and -13769 without it.
- Overrun: an `nd` 5 clocks after an accepted `nd`.
  - That sample is dropped and `ovf` goes to 1 and stays there.
  - The in-flight output is unchanged, and `rdy` still arrives 8 clocks after the first `nd`.
- Reset mid-MAC: `rst_n` is pulsed low 3 clocks after an `nd`.
  - No `rdy` is produced, and `dout` = 0 and `ovf` = 0.
  - A following impulse of 1000 reproduces the impulse sequence exactly.
- Back-to-back: `nd` every 8 clocks with ramp input 0,1,2,…
  - `rdy` is observed every 8 clocks with no missed samples.
  - The output tracks the ramp delayed by 6 samples, e.g. an input of 20 at the newest tap gives `dout` = 14.

Source files
------------

// File: rtl/cic_comp_fir.sv
// Serial 13-tap symmetric droop-compensation FIR feeding the CIC interpolator: one MAC per clock, seven clocks per output.
// Build option: define CIC_COMP_SAT_EN to clamp the output; otherwise the rounded result wraps to OUTPUT_WIDTH bits.
module cic_comp_fir #(
    parameter int INPUT_WIDTH  = 15,
    parameter int OUTPUT_WIDTH = 15,
    parameter int COEF_WIDTH   = 16,
    parameter int COEF_FRAC    = 14,
    parameter int NTAPS        = 13
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           nd,
    input  logic signed [INPUT_WIDTH-1:0]  din,
    output logic                           rdy,
    output logic signed [OUTPUT_WIDTH-1:0] dout,
    output logic                           ovf
);
    localparam int HALF   = (NTAPS + 1) / 2;
    localparam int IDX_W  = $clog2(NTAPS);
    localparam int PRE_W  = INPUT_WIDTH + 1;
    localparam int PROD_W = PRE_W + COEF_WIDTH;
    localparam int ACC_W  = PROD_W + 3;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    function automatic logic signed [COEF_WIDTH-1:0] coef(input logic [IDX_W-1:0] k);
        case (k)
            IDX_W'(0): coef = COEF_WIDTH'(12);
            IDX_W'(1): coef = COEF_WIDTH'(-40);
            IDX_W'(2): coef = COEF_WIDTH'(100);
            IDX_W'(3): coef = COEF_WIDTH'(-220);
            IDX_W'(4): coef = COEF_WIDTH'(240);
            IDX_W'(5): coef = COEF_WIDTH'(-1400);
            default:   coef = COEF_WIDTH'(19000);
        endcase
    endfunction

    function automatic logic signed [ACC_W-1:0] round_acc(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] half_lsb;
        half_lsb  = ACC_W'(1) <<< (COEF_FRAC - 1);
        round_acc = (a + half_lsb) >>> COEF_FRAC;
    endfunction

`ifdef CIC_COMP_SAT_EN
    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((64'sd1 <<< (OUTPUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

    function automatic logic signed [OUTPUT_WIDTH-1:0] sat_out(input logic signed [ACC_W-1:0] a);
        if (a > OUT_MAX)
            sat_out = OUTPUT_WIDTH'(OUT_MAX);
        else if (a < OUT_MIN)
            sat_out = OUTPUT_WIDTH'(OUT_MIN);
        else
            sat_out = OUTPUT_WIDTH'(a);
    endfunction
`else
    function automatic logic signed [OUTPUT_WIDTH-1:0] sat_out(input logic signed [ACC_W-1:0] a);
        sat_out = OUTPUT_WIDTH'(a);
    endfunction
`endif

    state_t                          state_q, state_d;
    logic        [IDX_W-1:0]         k_q, k_d;
    logic signed [ACC_W-1:0]         acc_q, acc_d;
    logic signed [INPUT_WIDTH-1:0]   x_q [NTAPS];
    logic signed [INPUT_WIDTH-1:0]   x_d [NTAPS];
    logic signed [OUTPUT_WIDTH-1:0]  dout_q, dout_d;
    logic                            rdy_q, rdy_d;
    logic                            ovf_q, ovf_d;

    logic        [IDX_W-1:0]         idx_b;
    logic signed [INPUT_WIDTH-1:0]   tap_a, tap_b;
    logic signed [PRE_W-1:0]         pre;
    logic signed [COEF_WIDTH-1:0]    coef_v;
    logic signed [PROD_W-1:0]        prod;
    logic                            accept;

    // Folded tap pair for index k; the centre tap has no partner, so it is not doubled.
    always_comb begin
        idx_b  = IDX_W'(NTAPS - 1) - k_q;
        tap_a  = x_q[k_q];
        tap_b  = (k_q == IDX_W'(HALF - 1)) ? '0 : x_q[idx_b];
        pre    = PRE_W'(tap_a) + PRE_W'(tap_b);
        coef_v = coef(k_q);
        prod   = pre * coef_v;
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        acc_d   = acc_q;
        x_d     = x_q;
        dout_d  = dout_q;
        rdy_d   = 1'b0;
        ovf_d   = ovf_q;
        accept  = nd && (state_q != S_MAC);

        case (state_q)
            S_MAC: begin
                acc_d = acc_q + ACC_W'(prod);
                if (k_q == IDX_W'(HALF - 1))
                    state_d = S_OUT;
                else
                    k_d = k_q + IDX_W'(1);
                if (nd)
                    ovf_d = 1'b1;
            end
            S_OUT: begin
                dout_d  = sat_out(round_acc(acc_q));
                rdy_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: ;
        endcase

        // OUT and the next accept share a cycle when samples arrive every 8 clocks.
        if (accept) begin
            x_d[0] = din;
            for (int i = 1; i < NTAPS; i++)
                x_d[i] = x_q[i-1];
            acc_d   = '0;
            k_d     = '0;
            state_d = S_MAC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            acc_q   <= '0;
            for (int i = 0; i < NTAPS; i++)
                x_q[i] <= '0;
            dout_q  <= '0;
            rdy_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            dout_q  <= dout_d;
            rdy_q   <= rdy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign rdy  = rdy_q;
    assign dout = dout_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_cic_comp_fir.sv
// Self-checking bench for cic_comp_fir: table vectors, directed corner sequences and random samples
// compared against a direct-form convolution model (honours CIC_COMP_SAT_EN).
module tb_cic_comp_fir;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               nd = 1'b0;
    logic signed [14:0] din = '0;
    logic               rdy;
    logic signed [14:0] dout;
    logic               ovf;

    cic_comp_fir dut (
        .clk  (clk),
        .rst_n(rst_n),
        .nd   (nd),
        .din  (din),
        .rdy  (rdy),
        .dout (dout),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int din;
        int exp_dout;
    } vec_t;

    typedef struct {
        longint dout;
        int     cyc;
    } exp_t;

`ifdef CIC_COMP_SAT_EN
    localparam int SAT_CENTRE = 16383;
`else
    localparam int SAT_CENTRE = -13769;
`endif

    int     H [13] = '{12, -40, 100, -220, 240, -1400, 19000, -1400, 240, -220, 100, -40, 12};
    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    longint hist[$];
    exp_t   eq[$];
    logic               prev_rdy = 1'b0;
    logic               prev_rst = 1'b0;
    logic signed [14:0] last_dout = '0;

    task automatic chk(input string name, input longint got, input longint want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic longint model_out();
        longint s = 0;
        longint r;
        for (int k = 0; k < 13; k++)
            s += longint'(H[k]) * hist[k];
        r = (s + 8192) >>> 14;
`ifdef CIC_COMP_SAT_EN
        if (r > 16383) r = 16383;
        if (r < -16384) r = -16384;
`else
        r = ((r % 32768) + 32768) % 32768;
        if (r >= 16384) r -= 32768;
`endif
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: every rdy must match the oldest outstanding expectation at the required cycle.
    always @(negedge clk) begin
        if (rst_n && rdy) begin
            if (eq.size() == 0) begin
                chk("unexpected_rdy", 1, 0);
            end else begin
                exp_t e;
                e = eq.pop_front();
                chk("dout", dout, e.dout);
                chk("rdy_cycle", cyc, e.cyc);
            end
        end
        if (rst_n && prev_rst && !rdy)
            chk("dout_hold", dout, last_dout);
        if (rst_n && prev_rdy && rdy)
            chk("rdy_double", 1, 0);
        prev_rdy  = rdy;
        prev_rst  = rst_n;
        last_dout = dout;
    end

    function automatic void hist_push(input int v);
        hist.push_front(longint'(v));
        while (hist.size() > 13)
            void'(hist.pop_back());
    endfunction

    task automatic send(input int v, input bit use_exp, input longint exp_v, input int gap);
        exp_t e;
        hist_push(v);
        e.dout = use_exp ? exp_v : model_out();
        e.cyc  = cyc + 9;
        eq.push_back(e);
        nd  = 1'b1;
        din = 15'(v);
        @(negedge clk);
        nd  = 1'b0;
        din = '0;
        repeat (7 + gap) @(negedge clk);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        nd    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rdy", rdy, 0);
        chk("rst_dout", dout, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        hist.delete();
        for (int i = 0; i < 13; i++) hist.push_back(0);
        eq.delete();
        @(negedge clk);
    endtask

    vec_t imp[14];

    initial begin
        imp[0]  = '{1000, 1};    imp[1]  = '{0, -2};    imp[2]  = '{0, 6};
        imp[3]  = '{0, -13};     imp[4]  = '{0, 15};    imp[5]  = '{0, -85};
        imp[6]  = '{0, 1160};    imp[7]  = '{0, -85};   imp[8]  = '{0, 15};
        imp[9]  = '{0, -13};     imp[10] = '{0, 6};     imp[11] = '{0, -2};
        imp[12] = '{0, 1};       imp[13] = '{0, 0};

        reset_dut();

        // Impulse response
        for (int i = 0; i < 14; i++)
            send(imp[i].din, 1'b1, longint'(imp[i].exp_dout), 0);

        // DC gain of one once the line is full
        for (int i = 0; i < 18; i++)
            send(1000, (i >= 12), 1000, 0);
        chk("dc_ovf", ovf, 0);

        // Full-scale impulse through the centre tap
        reset_dut();
        for (int i = 0; i < 13; i++)
            send((i == 0) ? 16383 : 0, (i == 6), longint'(SAT_CENTRE), 0);

        // Back-to-back ramp; newest tap 20 gives 14
        reset_dut();
        for (int i = 0; i <= 22; i++)
            send(i, (i == 20), 14, 0);

        // Overrun: second nd five clocks after the first is dropped
        begin
            exp_t e;
            hist_push(-3000);
            e.dout = model_out();
            e.cyc  = cyc + 9;
            eq.push_back(e);
            nd = 1'b1; din = -15'sd3000;
            @(negedge clk);
            nd = 1'b0; din = '0;
            repeat (4) @(negedge clk);
            nd = 1'b1; din = 15'sd7777;
            @(negedge clk);
            nd = 1'b0; din = '0;
            chk("ovf_set", ovf, 1);
            repeat (2) @(negedge clk);
        end
        for (int i = 0; i < 4; i++)
            send(500 * i, 1'b0, 0, 0);
        chk("ovf_sticky", ovf, 1);

        // Reset pulsed three clocks into the computation
        nd = 1'b1; din = 15'sd500;
        @(negedge clk);
        nd = 1'b0; din = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_rdy", rdy, 0);
        chk("midrst_dout", dout, 0);
        chk("midrst_ovf", ovf, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        hist.delete();
        for (int i = 0; i < 13; i++) hist.push_back(0);
        eq.delete();
        repeat (12) @(negedge clk);
        for (int i = 0; i < 14; i++)
            send(imp[i].din, 1'b1, longint'(imp[i].exp_dout), 0);

        // Random samples with random idle gaps
        for (int i = 0; i < 60; i++) begin
            int v;
            v = int'($urandom_range(0, 32767)) - 16384;
            send(v, 1'b0, 0, int'($urandom_range(0, 3)));
        end

        repeat (12) @(negedge clk);
        chk("drain", eq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
